// File: rtl/ptw_axi_read_arbiter_pkg.sv
// ptw_axi_read_arbiter_pkg: AXI encodings and FSM states shared by the PTW read arbiter
package ptw_axi_read_arbiter_pkg;
    localparam logic [7:0] AXI_LEN_SINGLE     = 8'd0;
    localparam logic [1:0] AXI_BURST_INCR     = 2'b01;
    localparam logic [2:0] AXI_SIZE_8B        = 3'b011;
    localparam logic [2:0] AXI_PROT_PRIV_DATA = 3'b001;
    localparam logic [1:0] AXI_RESP_OKAY      = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY    = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR    = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2
    } state_e;
endpackage

// File: rtl/ptw_req_slot.sv
// ptw_req_slot: holds one walker's pending walk request until its AR handshake completes
module ptw_req_slot #(
    parameter int unsigned ADDR_WIDTH = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  set_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  clr_i,
    output logic                  pend_o,
    output logic [ADDR_WIDTH-1:0] addr_o
);
    logic                  pend_q, pend_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    always_comb begin
        pend_d = set_i ? 1'b1 : (clr_i ? 1'b0 : pend_q);
        addr_d = set_i ? addr_i : addr_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= 1'b0;
            addr_q <= '0;
        end else begin
            pend_q <= pend_d;
            addr_q <= addr_d;
        end
    end

    assign pend_o = pend_q;
    assign addr_o = addr_q;

    // A walker keeps at most one walk in flight; a second pulse would overwrite the address.
    a_no_overwrite: assert property (@(posedge clk_i) disable iff (!rst_ni) !(set_i && pend_q));
endmodule

// File: rtl/ptw_axi_read_arbiter.sv
// ptw_axi_read_arbiter: round-robin merge of ITLB/DTLB walk reads onto one single-beat AXI read channel
module ptw_axi_read_arbiter
    import ptw_axi_read_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 64,
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned AXI_ID_WIDTH = 4,
    parameter int unsigned ITLB_ID      = 0,
    parameter int unsigned DTLB_ID      = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    itlb_addr_valid_i,
    input  logic [ADDR_WIDTH-1:0]   itlb_addr_i,
    output logic                    itlb_data_valid_o,
    output logic [DATA_WIDTH-1:0]   itlb_data_o,
    output logic                    itlb_bus_err_o,
    input  logic                    dtlb_addr_valid_i,
    input  logic [ADDR_WIDTH-1:0]   dtlb_addr_i,
    output logic                    dtlb_data_valid_o,
    output logic [DATA_WIDTH-1:0]   dtlb_data_o,
    output logic                    dtlb_bus_err_o,
    output logic                    m_arvalid_o,
    input  logic                    m_arready_i,
    output logic [ADDR_WIDTH-1:0]   m_araddr_o,
    output logic [AXI_ID_WIDTH-1:0] m_arid_o,
    output logic [7:0]              m_arlen_o,
    output logic [2:0]              m_arsize_o,
    output logic [1:0]              m_arburst_o,
    output logic [2:0]              m_arprot_o,
    input  logic                    m_rvalid_i,
    output logic                    m_rready_o,
    input  logic [DATA_WIDTH-1:0]   m_rdata_i,
    input  logic [1:0]              m_rresp_i,
    input  logic [AXI_ID_WIDTH-1:0] m_rid_i,
    input  logic                    m_rlast_i
);
    state_e                  state_q, state_d;
    logic                    last_q, last_d;  // last granted requester, i.e. owner of the transaction in flight
    logic [1:0]              pend, clr;
    logic [ADDR_WIDTH-1:0]   itlb_addr_q, dtlb_addr_q;
    logic [AXI_ID_WIDTH-1:0] win_id;
    logic                    r_done, r_ok;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    itlb_dv_q, itlb_dv_d, dtlb_dv_q, dtlb_dv_d;
    logic                    itlb_err_q, itlb_err_d, dtlb_err_q, dtlb_err_d;
    logic [DATA_WIDTH-1:0]   itlb_data_q, itlb_data_d, dtlb_data_q, dtlb_data_d;

    ptw_req_slot #(.ADDR_WIDTH(ADDR_WIDTH)) u_itlb_slot (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .set_i  (itlb_addr_valid_i),
        .addr_i (itlb_addr_i),
        .clr_i  (clr[0]),
        .pend_o (pend[0]),
        .addr_o (itlb_addr_q)
    );

    ptw_req_slot #(.ADDR_WIDTH(ADDR_WIDTH)) u_dtlb_slot (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .set_i  (dtlb_addr_valid_i),
        .addr_i (dtlb_addr_i),
        .clr_i  (clr[1]),
        .pend_o (pend[1]),
        .addr_o (dtlb_addr_q)
    );

    assign win_id = last_q ? AXI_ID_WIDTH'(DTLB_ID) : AXI_ID_WIDTH'(ITLB_ID);
    assign r_done = (state_q == ST_R) && m_rvalid_i;
    // Anything but a clean single-beat OKAY from the right ID returns an invalid PTE.
    assign r_ok   = (m_rid_i == win_id) && m_rlast_i && (m_rresp_i == AXI_RESP_OKAY);
    assign r_data = r_ok ? m_rdata_i : '0;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        clr     = '0;
        case (state_q)
            ST_IDLE: if (|pend) begin
                last_d  = &pend ? ~last_q : pend[1];
                state_d = ST_AR;
            end
            ST_AR: if (m_arready_i) begin
                clr     = last_q ? 2'b10 : 2'b01;
                state_d = ST_R;
            end
            ST_R: if (m_rvalid_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        itlb_dv_d   = r_done && !last_q;
        dtlb_dv_d   = r_done && last_q;
        itlb_err_d  = itlb_dv_d && !r_ok;
        dtlb_err_d  = dtlb_dv_d && !r_ok;
        itlb_data_d = itlb_dv_d ? r_data : itlb_data_q;
        dtlb_data_d = dtlb_dv_d ? r_data : dtlb_data_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            itlb_dv_q   <= 1'b0;
            dtlb_dv_q   <= 1'b0;
            itlb_err_q  <= 1'b0;
            dtlb_err_q  <= 1'b0;
            itlb_data_q <= '0;
            dtlb_data_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            itlb_dv_q   <= itlb_dv_d;
            dtlb_dv_q   <= dtlb_dv_d;
            itlb_err_q  <= itlb_err_d;
            dtlb_err_q  <= dtlb_err_d;
            itlb_data_q <= itlb_data_d;
            dtlb_data_q <= dtlb_data_d;
        end
    end

    assign m_arvalid_o       = (state_q == ST_AR);
    assign m_araddr_o        = m_arvalid_o ? (last_q ? dtlb_addr_q : itlb_addr_q) : '0;
    assign m_arid_o          = m_arvalid_o ? win_id : '0;
    assign m_arlen_o         = AXI_LEN_SINGLE;
    assign m_arsize_o        = AXI_SIZE_8B;
    assign m_arburst_o       = AXI_BURST_INCR;
    assign m_arprot_o        = AXI_PROT_PRIV_DATA;
    assign m_rready_o        = (state_q == ST_R);
    assign itlb_data_valid_o = itlb_dv_q;
    assign dtlb_data_valid_o = dtlb_dv_q;
    assign itlb_bus_err_o    = itlb_err_q;
    assign dtlb_bus_err_o    = dtlb_err_q;
    assign itlb_data_o       = itlb_data_q;
    assign dtlb_data_o       = dtlb_data_q;
endmodule

// File: tb/tb_ptw_axi_read_arbiter.sv
// tb_ptw_axi_read_arbiter: directed and random walks against a transaction-level arbiter model
module tb_ptw_axi_read_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        itlb_v = 1'b0, dtlb_v = 1'b0;
    logic [63:0] itlb_a = '0, dtlb_a = '0;
    logic        itlb_dv, dtlb_dv, itlb_err, dtlb_err;
    logic [63:0] itlb_data, dtlb_data;
    logic        arvalid, arready = 1'b0, rvalid = 1'b0, rready, rlast = 1'b0;
    logic [63:0] araddr, rdata = '0;
    logic [3:0]  arid, rid = '0;
    logic [7:0]  arlen;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst, rresp = '0;

    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    ptw_axi_read_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n),
        .itlb_addr_valid_i(itlb_v), .itlb_addr_i(itlb_a), .itlb_data_valid_o(itlb_dv),
        .itlb_data_o(itlb_data), .itlb_bus_err_o(itlb_err),
        .dtlb_addr_valid_i(dtlb_v), .dtlb_addr_i(dtlb_a), .dtlb_data_valid_o(dtlb_dv),
        .dtlb_data_o(dtlb_data), .dtlb_bus_err_o(dtlb_err),
        .m_arvalid_o(arvalid), .m_arready_i(arready), .m_araddr_o(araddr), .m_arid_o(arid),
        .m_arlen_o(arlen), .m_arsize_o(arsize), .m_arburst_o(arburst), .m_arprot_o(arprot),
        .m_rvalid_i(rvalid), .m_rready_o(rready), .m_rdata_i(rdata), .m_rresp_i(rresp),
        .m_rid_i(rid), .m_rlast_i(rlast)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // AXI slave: directed knobs, or random delays/responses in rnd_mode
    bit          rnd_mode = 0, bad_id_v = 0, bad_last_v = 0;
    int          ar_wait_v = 0, r_wait_v = 0;
    logic [1:0]  resp_v = '0;
    logic [63:0] data_v = '0;
    int          ar_cnt = 0, r_cnt = 0, ar_w = 0, r_w = 0;
    logic [3:0]  hs_id = '0;
    bit          s_bad_id, s_bad_last;
    logic [1:0]  s_resp;
    logic [63:0] s_data;

    always begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            arready = 0; rvalid = 0; ar_cnt = 0; r_cnt = 0;
        end else begin
            if (arvalid) begin
                if (ar_cnt == 0) ar_w = rnd_mode ? int'($urandom_range(0, 4)) : ar_wait_v;
                arready = (ar_cnt >= ar_w);
                hs_id = arid;
                ar_cnt++;
            end else begin
                arready = 0; ar_cnt = 0;
            end
            if (rready) begin
                if (r_cnt == 0) begin
                    if (rnd_mode) begin
                        r_w        = int'($urandom_range(0, 5));
                        s_resp     = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
                        s_data     = {$urandom, $urandom};
                        s_bad_id   = ($urandom_range(0, 9) == 0);
                        s_bad_last = ($urandom_range(0, 9) == 0);
                    end else begin
                        r_w = r_wait_v; s_resp = resp_v; s_data = data_v;
                        s_bad_id = bad_id_v; s_bad_last = bad_last_v;
                    end
                end
                rvalid = (r_cnt >= r_w);
                rid    = s_bad_id ? (hs_id ^ 4'h1) : hs_id;
                rlast  = !s_bad_last;
                rresp  = s_resp;
                rdata  = s_data;
                r_cnt++;
            end else begin
                rvalid = 0; r_cnt = 0;
            end
        end
    end

    // Reference model: pending walks per requester, one transaction in flight, RR fairness
    bit          pend_m[2], exp_dv_m[2], exp_err_m[2];
    logic [63:0] paddr_m[2], exp_data_m[2];
    bit          busy_m, ar_done_m, last_m, was_busy, ok_m;
    logic [63:0] exp_addr;
    int          dv_cnt[2], err_cnt[2], ar_hs = 0;
    logic [63:0] ar_log[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                pend_m[i] = 0; exp_dv_m[i] = 0; exp_err_m[i] = 0; exp_data_m[i] = '0;
            end
            busy_m = 0; ar_done_m = 0; last_m = 1;
        end else begin
            chk("itlb_dv", 64'(itlb_dv), 64'(exp_dv_m[0]));
            chk("dtlb_dv", 64'(dtlb_dv), 64'(exp_dv_m[1]));
            chk("itlb_data", itlb_data, exp_data_m[0]);
            chk("dtlb_data", dtlb_data, exp_data_m[1]);
            if (exp_dv_m[0]) chk("itlb_err", 64'(itlb_err), 64'(exp_err_m[0]));
            if (exp_dv_m[1]) chk("dtlb_err", 64'(dtlb_err), 64'(exp_err_m[1]));
            if (itlb_dv) begin dv_cnt[0]++; if (itlb_err) err_cnt[0]++; end
            if (dtlb_dv) begin dv_cnt[1]++; if (dtlb_err) err_cnt[1]++; end
            exp_dv_m[0] = 0; exp_dv_m[1] = 0;
            was_busy = busy_m;
            chk("arvalid", 64'(arvalid), 64'(busy_m && !ar_done_m));
            chk("rready", 64'(rready), 64'(busy_m && ar_done_m));
            if (busy_m && !ar_done_m) begin
                chk("araddr", araddr, exp_addr);
                chk("arid", 64'(arid), 64'(last_m));
                if (arvalid && arready) begin
                    ar_done_m = 1; pend_m[last_m] = 0; ar_hs++; ar_log.push_back(araddr);
                end
            end else if (busy_m && rvalid && rready) begin
                ok_m = (rid == 4'(last_m)) && rlast && (rresp == 2'b00);
                exp_dv_m[last_m]   = 1;
                exp_err_m[last_m]  = !ok_m;
                exp_data_m[last_m] = ok_m ? rdata : 64'd0;
                busy_m = 0; ar_done_m = 0;
            end
            if (!was_busy && (pend_m[0] || pend_m[1])) begin
                last_m   = (pend_m[0] && pend_m[1]) ? !last_m : pend_m[1];
                busy_m   = 1;
                exp_addr = paddr_m[last_m];
            end
            if (itlb_v) begin pend_m[0] = 1; paddr_m[0] = itlb_a; end
            if (dtlb_v) begin pend_m[1] = 1; paddr_m[1] = dtlb_a; end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            itlb_v = 0; dtlb_v = 0;
        end
    endtask

    task automatic pulse(input bit i, input bit d, input logic [63:0] ai, input logic [63:0] ad);
        itlb_v = i; itlb_a = ai; dtlb_v = d; dtlb_a = ad;
        cyc(1);
    endtask

    task automatic do_reset();
        rst_n = 0;
        cyc(2);
        rst_n = 1;
        cyc(1);
    endtask

    int  b_ar, b_dv0, b_dv1, b_er0, b_er1, n_req;
    bit  out_w[2];

    task automatic snap();
        b_ar = ar_hs; b_dv0 = dv_cnt[0]; b_dv1 = dv_cnt[1]; b_er0 = err_cnt[0]; b_er1 = err_cnt[1];
    endtask

    initial begin
        cyc(3);
        chk("rst_arvalid", 64'(arvalid), 0);
        chk("rst_rready", 64'(rready), 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_arid", 64'(arid), 0);
        chk("rst_dv", 64'({itlb_dv, dtlb_dv, itlb_err, dtlb_err}), 0);
        chk("rst_data", itlb_data | dtlb_data, 0);
        chk("arlen", 64'(arlen), 0);
        chk("arsize", 64'(arsize), 3);
        chk("arburst", 64'(arburst), 1);
        chk("arprot", 64'(arprot), 1);
        rst_n = 1;
        cyc(2);

        // single DTLB walk
        r_wait_v = 3; data_v = 64'h2000_04CF; snap();
        pulse(0, 1, '0, 64'h8000_1008);
        cyc(15);
        chk("t1_ar_count", 64'(ar_hs - b_ar), 1);
        chk("t1_araddr", ar_log[$], 64'h8000_1008);
        chk("t1_dtlb_dv", 64'(dv_cnt[1] - b_dv1), 1);
        chk("t1_itlb_dv", 64'(dv_cnt[0] - b_dv0), 0);
        chk("t1_data", dtlb_data, 64'h2000_04CF);

        // simultaneous requests after reset: ITLB served first
        do_reset(); snap();
        pulse(1, 1, 64'h1000, 64'h2000);
        cyc(25);
        chk("t2_ar_count", 64'(ar_hs - b_ar), 2);
        chk("t2_first", ar_log[$-1], 64'h1000);
        chk("t2_second", ar_log[$], 64'h2000);
        chk("t2_dv", 64'({dv_cnt[0] - b_dv0, dv_cnt[1] - b_dv1}), {32'd1, 32'd1});

        // ARREADY stall with a request queued behind it
        ar_wait_v = 10; snap();
        pulse(0, 1, '0, 64'h3008);
        cyc(4);
        chk("t3_stalled", 64'(arvalid), 1);
        pulse(1, 0, 64'h4010, '0);
        cyc(40);
        ar_wait_v = 0;
        chk("t3_first", ar_log[$-1], 64'h3008);
        chk("t3_second", ar_log[$], 64'h4010);
        chk("t3_dv", 64'({dv_cnt[0] - b_dv0, dv_cnt[1] - b_dv1}), {32'd1, 32'd1});

        // SLVERR response
        resp_v = 2'b10; data_v = 64'hFFFF; snap();
        pulse(1, 0, 64'h5000, '0);
        cyc(15);
        resp_v = 2'b00;
        chk("t4_err", 64'(err_cnt[0] - b_er0), 1);
        chk("t4_data", itlb_data, 0);
        chk("t4_idle", 64'({arvalid, rready}), 0);

        // RID mismatch, then RLAST low
        data_v = 64'hABCD; bad_id_v = 1; snap();
        pulse(0, 1, '0, 64'h6008);
        cyc(15);
        bad_id_v = 0;
        chk("t5_rid_err", 64'(err_cnt[1] - b_er1), 1);
        chk("t5_rid_data", dtlb_data, 0);
        bad_last_v = 1; snap();
        pulse(1, 0, 64'h6010, '0);
        cyc(15);
        bad_last_v = 0;
        chk("t5_rlast_err", 64'(err_cnt[0] - b_er0), 1);
        chk("t5_rlast_data", itlb_data, 0);

        // reset while waiting in R
        r_wait_v = 8; data_v = 64'h55AA;
        pulse(1, 0, 64'h7000, '0);
        cyc(4);
        chk("t6_in_r", 64'(rready), 1);
        #2 rst_n = 0;
        #1;
        chk("t6_rst_bus", 64'({arvalid, rready, itlb_dv, dtlb_dv, itlb_err, dtlb_err}), 0);
        chk("t6_rst_data", itlb_data | dtlb_data, 0);
        cyc(2);
        rst_n = 1;
        r_wait_v = 1; data_v = 64'h1234; snap();
        cyc(1);
        pulse(0, 1, '0, 64'h7008);
        cyc(15);
        chk("t6_fresh_dv", 64'(dv_cnt[1] - b_dv1), 1);
        chk("t6_fresh_data", dtlb_data, 64'h1234);

        // random walkers, each with at most one walk outstanding
        rnd_mode = 1; n_req = 0; out_w[0] = 0; out_w[1] = 0; snap();
        repeat (3000) begin
            if (itlb_dv) out_w[0] = 0;
            if (dtlb_dv) out_w[1] = 0;
            if (!out_w[0] && $urandom_range(0, 3) == 0) begin
                itlb_v = 1; itlb_a = {$urandom, $urandom} & ~64'h7; out_w[0] = 1; n_req++;
            end
            if (!out_w[1] && $urandom_range(0, 3) == 0) begin
                dtlb_v = 1; dtlb_a = {$urandom, $urandom} & ~64'h7; out_w[1] = 1; n_req++;
            end
            cyc(1);
        end
        for (int i = 0; i < 200 && (out_w[0] || out_w[1]); i++) begin
            if (itlb_dv) out_w[0] = 0;
            if (dtlb_dv) out_w[1] = 0;
            cyc(1);
        end
        chk("rand_drain", 64'(out_w[0] || out_w[1]), 0);
        chk("rand_complete", 64'(dv_cnt[0] + dv_cnt[1] - b_dv0 - b_dv1), 64'(n_req));
        chk("rand_ar_count", 64'(ar_hs - b_ar), 64'(n_req));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
